// File: rtl/ps2_rx_fifo.sv
`timescale 1ns/1ps
// PS/2 device-to-host receiver on the system clock: synchronises and
// glitch-filters the PS/2 pins, frames start/data/parity/stop bits, checks
// odd parity and the stop bit, aborts stalled frames, and buffers good scan
// codes in a first-word-fall-through FIFO with sticky error reporting.
module ps2_rx_fifo #(
    parameter int DATA_BITS      = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                ps2_clk_i,
    input  logic                                ps2_data_i,
    input  logic                                rd_en_i,
    input  logic                                err_clr_i,
    output logic [DATA_BITS-1:0]                data_out_o,
    output logic                                valid_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     count_o,
    output logic                                bsy_o,
    output logic                                parity_err_o,
    output logic                                frame_err_o,
    output logic                                overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]           clkSync_q, dataSync_q;
    logic                 clkFilt_q, dataFilt_q, clkFiltPrev_q;
    logic [FW-1:0]        clkFiltCnt_q, dataFiltCnt_q;
    logic                 fallStrobe;

    state_t               state_q, state_d;
    logic [BW-1:0]        bitCnt_q, bitCnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [TW-1:0]        toCnt_q, toCnt_d;
    logic                 pushEn, setParity, setFrame, setOverflow;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wrPtr_q, rdPtr_q;
    logic [CW-1:0]        count_q;
    logic [DATA_BITS-1:0] lastOut_q;
    logic                 popEn, fifoFull;
    logic                 parityErr_q, frameErr_q, overflow_q;

    // Two-flop synchronisers; preset high so reset looks like an idle bus.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2_clk_i};
            dataSync_q <= {dataSync_q[0], ps2_data_i};
        end
    end

    // Clock-line filter: follow the synchronised level only after FILTER_LEN agreeing samples.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clkFilt_q    <= 1'b1;
            clkFiltCnt_q <= '0;
        end else if (clkSync_q[1] != clkFilt_q) begin
            if (clkFiltCnt_q == FW'(FILTER_LEN - 1)) begin
                clkFilt_q    <= clkSync_q[1];
                clkFiltCnt_q <= '0;
            end else begin
                clkFiltCnt_q <= clkFiltCnt_q + FW'(1);
            end
        end else begin
            clkFiltCnt_q <= '0;
        end
    end

    // Data-line filter, identical behaviour to the clock-line filter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dataFilt_q    <= 1'b1;
            dataFiltCnt_q <= '0;
        end else if (dataSync_q[1] != dataFilt_q) begin
            if (dataFiltCnt_q == FW'(FILTER_LEN - 1)) begin
                dataFilt_q    <= dataSync_q[1];
                dataFiltCnt_q <= '0;
            end else begin
                dataFiltCnt_q <= dataFiltCnt_q + FW'(1);
            end
        end else begin
            dataFiltCnt_q <= '0;
        end
    end

    // Delayed filtered clock for falling-edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) clkFiltPrev_q <= 1'b1;
        else       clkFiltPrev_q <= clkFilt_q;
    end

    assign fallStrobe = clkFiltPrev_q & ~clkFilt_q;
    assign fifoFull   = (count_q == CW'(FIFO_DEPTH));
    assign valid_o    = (count_q != '0);
    assign popEn      = rd_en_i & valid_o;

    // Frame FSM and timeout counter: registered state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            toCnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            toCnt_q  <= toCnt_d;
        end
    end

    // Frame FSM next state: bit capture, stop-bit checks, and stall abort.
    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        toCnt_d     = '0;
        pushEn      = 1'b0;
        setParity   = 1'b0;
        setFrame    = 1'b0;
        setOverflow = 1'b0;

        if (state_q != IDLE && !fallStrobe) toCnt_d = toCnt_q + TW'(1);

        case (state_q)
            IDLE: begin
                if (fallStrobe && !dataFilt_q) begin
                    state_d  = DATA;
                    bitCnt_d = '0;
                end
            end
            DATA: begin
                if (fallStrobe) begin
                    shift_d  = {dataFilt_q, shift_q[DATA_BITS-1:1]};
                    bitCnt_d = bitCnt_q + BW'(1);
                    if (bitCnt_q == BW'(DATA_BITS - 1)) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fallStrobe) begin
                    parity_d = dataFilt_q;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fallStrobe) begin
                    state_d = IDLE;
                    if (!dataFilt_q)                 setFrame    = 1'b1;
                    else if (!(^shift_q ^ parity_q)) setParity   = 1'b1;
                    else if (fifoFull && !popEn)     setOverflow = 1'b1;
                    else                             pushEn      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && !fallStrobe && toCnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d  = IDLE;
            toCnt_d  = '0;
            setFrame = 1'b1;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk_i) begin
        if (pushEn) mem_q[wrPtr_q] <= shift_q;
    end

    // FIFO pointers, occupancy and the last popped word shown while empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            lastOut_q <= '0;
        end else begin
            if (pushEn) wrPtr_q <= wrPtr_q + AW'(1);
            if (popEn) begin
                rdPtr_q   <= rdPtr_q + AW'(1);
                lastOut_q <= mem_q[rdPtr_q];
            end
            if (pushEn && !popEn)      count_q <= count_q + CW'(1);
            else if (popEn && !pushEn) count_q <= count_q - CW'(1);
        end
    end

    // Sticky error flags; a new error in the same cycle beats the clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            parityErr_q <= 1'b0;
            frameErr_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            parityErr_q <= (parityErr_q & ~err_clr_i) | setParity;
            frameErr_q  <= (frameErr_q  & ~err_clr_i) | setFrame;
            overflow_q  <= (overflow_q  & ~err_clr_i) | setOverflow;
        end
    end

    assign data_out_o   = valid_o ? mem_q[rdPtr_q] : lastOut_q;
    assign count_o      = count_q;
    assign bsy_o        = (state_q != IDLE);
    assign parity_err_o = parityErr_q;
    assign frame_err_o  = frameErr_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
`timescale 1ns/1ps
// Scoreboard bench for ps2_rx_fifo: directed PS/2 frames with hand-computed
// parity; expected scan codes are queued as frames are sent and a monitor
// compares the FIFO head whenever it pops.
module tb_ps2_rx_fifo;

    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2Clk, ps2Data, rdEn, errClr;
    logic [7:0] dataOut;
    logic       valid, bsy, parityErr, frameErr, overflow;
    logic [2:0] count;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] expQ[$];
    logic       drainEn = 1'b0;
    logic       popReq  = 1'b0;

    ps2_rx_fifo #(
        .DATA_BITS(8), .FIFO_DEPTH(4), .FILTER_LEN(4), .TIMEOUT_CYCLES(200)
    ) dut (
        .clk_i(clk), .rst_i(rst), .ps2_clk_i(ps2Clk), .ps2_data_i(ps2Data),
        .rd_en_i(rdEn), .err_clr_i(errClr), .data_out_o(dataOut),
        .valid_o(valid), .count_o(count), .bsy_o(bsy),
        .parity_err_o(parityErr), .frame_err_o(frameErr), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    // Abort a run that stops making progress.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the FIFO when asked and compares the head against the scoreboard.
    initial begin
        rdEn = 1'b0;
        forever begin
            @(negedge clk);
            if (valid && (drainEn || popReq)) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL scoreboard unexpected word actual=%0h expected=none", dataOut);
                end else begin
                    logic [7:0] exp;
                    exp = expQ.pop_front();
                    if (dataOut !== exp) begin
                        errors++;
                        $display("[TB] FAIL scoreboard data actual=%0h expected=%0h", dataOut, exp);
                    end
                end
                rdEn = 1'b1;
            end else begin
                rdEn = 1'b0;
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseErrClr();
        @(posedge clk); #1 errClr = 1'b1;
        @(posedge clk); #1 errClr = 1'b0;
    endtask

    task automatic drain();
        @(posedge clk); #1 drainEn = 1'b1;
        repeat (8) @(posedge clk);
        #1 drainEn = 1'b0;
        waitCycles(2);
    endtask

    task automatic sendBit(input logic b);
        @(negedge clk); ps2Data = b;
        waitCycles(HALF);
        ps2Clk = 1'b0;
        waitCycles(HALF);
        ps2Clk = 1'b1;
    endtask

    // One full frame; popOnStop lines a single pop up with the stop-bit strobe.
    task automatic applyStimulus(input logic [7:0] code, input logic parityBit,
                                 input logic stopBit, input logic popOnStop);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(code[i]);
        sendBit(parityBit);
        checkOutput("bsy_mid_frame", 32'(bsy), 32'd1);
        @(negedge clk); ps2Data = stopBit;
        waitCycles(HALF);
        ps2Clk = 1'b0;
        if (popOnStop) begin
            repeat (6) @(posedge clk);
            #1;
            checkOutput("bsy_before_stop_strobe", 32'(bsy), 32'd1);
            popReq = 1'b1;
            @(posedge clk);
            #1;
            popReq = 1'b0;
            checkOutput("bsy_after_stop_strobe", 32'(bsy), 32'd0);
            checkOutput("count_push_pop_full", 32'(count), 32'd4);
            waitCycles(HALF - 8);
        end else begin
            waitCycles(HALF);
        end
        ps2Clk = 1'b1;
        @(negedge clk); ps2Data = 1'b1;
        waitCycles(HALF);
    endtask

    // Directed test sequence.
    initial begin
        int waited;
        rst = 1'b1; ps2Clk = 1'b1; ps2Data = 1'b1; errClr = 1'b0;

        $display("[TB] reset");
        waitCycles(5);
        @(negedge clk); rst = 1'b0;
        waitCycles(5);
        checkOutput("rst_data_out", 32'(dataOut), 32'h0);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_bsy", 32'(bsy), 32'd0);
        checkOutput("rst_flags", 32'({parityErr, frameErr, overflow}), 32'd0);

        $display("[TB] good frame 15");
        expQ.push_back(8'h15);
        applyStimulus(8'h15, 1'b0, 1'b1, 1'b0);
        checkOutput("good_valid", 32'(valid), 32'd1);
        checkOutput("good_count", 32'(count), 32'd1);
        checkOutput("good_data", 32'(dataOut), 32'h15);
        checkOutput("good_flags", 32'({parityErr, frameErr, overflow}), 32'd0);
        checkOutput("good_bsy_after", 32'(bsy), 32'd0);
        drain();
        checkOutput("pop_valid", 32'(valid), 32'd0);
        checkOutput("pop_count", 32'(count), 32'd0);
        checkOutput("pop_data_hold", 32'(dataOut), 32'h15);

        $display("[TB] parity error");
        applyStimulus(8'h15, 1'b1, 1'b1, 1'b0);
        checkOutput("par_count", 32'(count), 32'd0);
        checkOutput("par_valid", 32'(valid), 32'd0);
        checkOutput("par_flag", 32'(parityErr), 32'd1);
        pulseErrClr();
        checkOutput("par_flag_cleared", 32'(parityErr), 32'd0);

        $display("[TB] stop bit error and timeout");
        applyStimulus(8'h15, 1'b0, 1'b0, 1'b0);
        checkOutput("stop_frame_err", 32'(frameErr), 32'd1);
        checkOutput("stop_count", 32'(count), 32'd0);
        checkOutput("stop_parity_err", 32'(parityErr), 32'd0);
        pulseErrClr();
        checkOutput("stop_flag_cleared", 32'(frameErr), 32'd0);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        sendBit(1'b0);
        @(negedge clk); ps2Data = 1'b1;
        waitCycles(100);
        checkOutput("to_bsy_before", 32'(bsy), 32'd1);
        checkOutput("to_flag_before", 32'(frameErr), 32'd0);
        waited = 0;
        while (bsy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("to_bsy_dropped", 32'(bsy), 32'd0);
        checkOutput("to_frame_err", 32'(frameErr), 32'd1);
        pulseErrClr();
        expQ.push_back(8'h1C);
        applyStimulus(8'h1C, 1'b0, 1'b1, 1'b0);
        checkOutput("after_to_count", 32'(count), 32'd1);
        checkOutput("after_to_data", 32'(dataOut), 32'h1C);
        checkOutput("after_to_flags", 32'({parityErr, frameErr, overflow}), 32'd0);
        drain();

        $display("[TB] fifo fill and overflow");
        expQ.push_back(8'h01);
        applyStimulus(8'h01, 1'b0, 1'b1, 1'b0);
        expQ.push_back(8'h02);
        applyStimulus(8'h02, 1'b0, 1'b1, 1'b0);
        expQ.push_back(8'h03);
        applyStimulus(8'h03, 1'b1, 1'b1, 1'b0);
        expQ.push_back(8'h04);
        applyStimulus(8'h04, 1'b0, 1'b1, 1'b0);
        checkOutput("fill_overflow_before", 32'(overflow), 32'd0);
        applyStimulus(8'h05, 1'b1, 1'b1, 1'b0);
        checkOutput("full_count", 32'(count), 32'd4);
        checkOutput("full_overflow", 32'(overflow), 32'd1);
        checkOutput("full_head", 32'(dataOut), 32'h01);
        checkOutput("full_other_flags", 32'({parityErr, frameErr}), 32'd0);
        pulseErrClr();
        checkOutput("overflow_cleared", 32'(overflow), 32'd0);
        expQ.push_back(8'h06);
        applyStimulus(8'h06, 1'b1, 1'b1, 1'b1);
        checkOutput("pushpop_overflow", 32'(overflow), 32'd0);
        checkOutput("pushpop_count", 32'(count), 32'd4);
        checkOutput("pushpop_head", 32'(dataOut), 32'h02);
        drain();
        checkOutput("drained_count", 32'(count), 32'd0);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] glitch filter");
        @(negedge clk); ps2Data = 1'b0;
        waitCycles(10);
        ps2Clk = 1'b0;
        waitCycles(3);
        ps2Clk = 1'b1;
        waitCycles(20);
        checkOutput("glitch_short_bsy", 32'(bsy), 32'd0);
        ps2Clk = 1'b0;
        waitCycles(4);
        ps2Clk = 1'b1;
        waitCycles(10);
        checkOutput("glitch_long_bsy", 32'(bsy), 32'd1);
        @(negedge clk); ps2Data = 1'b1;
        waitCycles(250);
        checkOutput("glitch_timeout_bsy", 32'(bsy), 32'd0);
        checkOutput("glitch_timeout_err", 32'(frameErr), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
